// File: rtl/tile_config_mem_shadowed_if.sv
// Bus bundle for the shadowed tile configuration memory: frame writes,
// commit/abort handshake, readback and the active configuration outputs.
interface tile_config_mem_shadowed_if #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 0,
  parameter int RbSelWidth      = 5
);
  // A zero-bit configuration still needs a legal port, so keep one tied-off bit.
  localparam int CfgW = (NoConfigBits > 0) ? NoConfigBits : 1;

  logic [FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic                       commit_req;
  logic                       commit_ack;
  logic                       abort;
  logic [RbSelWidth-1:0]      ReadbackSel;
  logic [FrameBitsPerRow-1:0] ReadbackData;
  logic [MaxFramesPerCol-1:0] frames_dirty;
  logic                       busy;
  logic [CfgW-1:0]            ConfigBits;
  logic [CfgW-1:0]            ConfigBits_N;

  modport master (
    output FrameData, FrameStrobe, commit_req, abort, ReadbackSel,
    input  commit_ack, ReadbackData, frames_dirty, busy, ConfigBits, ConfigBits_N
  );

  modport slave (
    input  FrameData, FrameStrobe, commit_req, abort, ReadbackSel,
    output commit_ack, ReadbackData, frames_dirty, busy, ConfigBits, ConfigBits_N
  );
endinterface

// File: rtl/tile_config_mem_shadowed.sv
// Frame-addressed configuration memory with a shadow bank that is copied
// atomically into the active bank through a 4-phase commit handshake.
module tile_config_mem_shadowed #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NoConfigBits    = 0,
  parameter logic [MaxFramesPerCol*FrameBitsPerRow-1:0] Init_Bitstream = '0,
  parameter int RbSelWidth      = 5
) (
  input logic CLK,
  input logic resetn,
  tile_config_mem_shadowed_if.slave bus
);

  localparam int TotalBits = MaxFramesPerCol * FrameBitsPerRow;
  localparam int CfgW      = (NoConfigBits > 0) ? NoConfigBits : 1;
  localparam logic [CfgW-1:0] InitCfg = (NoConfigBits > 0) ? Init_Bitstream[CfgW-1:0] : '0;

  typedef enum logic [2:0] {IDLE, COPY, ACK, WAIT_LOW, REVERT} state_t;

  state_t                     r_state;
  logic [CfgW-1:0]            r_shadow;
  logic [CfgW-1:0]            r_active;
  logic [MaxFramesPerCol-1:0] r_dirty;
  logic                       r_ack;
  logic [FrameBitsPerRow-1:0] r_rbData;

  logic [CfgW-1:0]            w_shadowWr;
  logic [TotalBits-1:0]       w_shadowPad;
  logic [FrameBitsPerRow-1:0] w_rbFrame;

  // Only stored bits can be written; bits past NoConfigBits simply do not exist.
  always_comb begin
    w_shadowWr = r_shadow;
    if (NoConfigBits > 0) begin
      for (int i = 0; i < CfgW; i++) begin
        if (bus.FrameStrobe[i / FrameBitsPerRow]) w_shadowWr[i] = bus.FrameData[i % FrameBitsPerRow];
      end
    end
  end

  always_comb begin
    w_shadowPad = '0;
    w_shadowPad[CfgW-1:0] = r_shadow;
    w_rbFrame = '0;
    for (int f = 0; f < MaxFramesPerCol; f++) begin
      if (int'(bus.ReadbackSel) == f) w_rbFrame = w_shadowPad[f*FrameBitsPerRow +: FrameBitsPerRow];
    end
  end

  // Default path applies frame writes; COPY and REVERT override bank/dirty updates.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_shadow <= InitCfg;
      r_active <= InitCfg;
      r_dirty  <= '0;
      r_ack    <= 1'b0;
      r_rbData <= '0;
    end else begin
      r_rbData <= w_rbFrame;
      r_shadow <= w_shadowWr;
      r_dirty  <= r_dirty | bus.FrameStrobe;
      case (r_state)
        IDLE: begin
          if (bus.abort) begin
            r_shadow <= r_shadow;
            r_dirty  <= r_dirty;
            r_state  <= REVERT;
          end else if (bus.commit_req) begin
            r_state <= COPY;
          end
        end
        COPY: begin
          r_active <= r_shadow;
          r_dirty  <= bus.FrameStrobe;
          r_ack    <= 1'b1;
          r_state  <= ACK;
        end
        ACK: r_state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!bus.commit_req) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        REVERT: begin
          r_shadow <= r_active;
          r_dirty  <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ConfigBits   = r_active;
  assign bus.ConfigBits_N = ~r_active;
  assign bus.commit_ack   = r_ack;
  assign bus.ReadbackData = r_rbData;
  assign bus.frames_dirty = r_dirty;
  assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_tile_config_mem_shadowed.sv
// Self-checking bench: frame-level reference model of shadow/active banks,
// directed scenarios plus a randomized write/readback/commit/abort mix.
module tb_tile_config_mem_shadowed;

  localparam int NF   = 20;
  localparam int FB   = 32;
  localparam int NCB  = 600;
  localparam int RSW  = 5;
  localparam logic [NF*FB-1:0] INIT = 640'h20;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  logic [FB-1:0]   mShadow [NF];
  logic [FB-1:0]   mActive [NF];
  logic [NF-1:0]   mDirty;

  tile_config_mem_shadowed_if #(
    .MaxFramesPerCol(NF), .FrameBitsPerRow(FB), .NoConfigBits(NCB), .RbSelWidth(RSW)
  ) bus ();

  tile_config_mem_shadowed #(
    .MaxFramesPerCol(NF), .FrameBitsPerRow(FB), .NoConfigBits(NCB),
    .Init_Bitstream(INIT), .RbSelWidth(RSW)
  ) dut (
    .CLK(clk),
    .resetn(resetn),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Stored-bit mask of a frame: full, partial (frame 18) or empty (frame 19).
  function automatic logic [FB-1:0] fmask(int f);
    if (f * FB >= NCB) return '0;
    if ((f + 1) * FB <= NCB) return '1;
    return (32'h1 << (NCB - f * FB)) - 32'h1;
  endfunction

  function automatic logic [NCB-1:0] expCfg();
    logic [NF*FB-1:0] t;
    t = '0;
    for (int f = 0; f < NF; f++) t[f*FB +: FB] = mActive[f];
    return t[NCB-1:0];
  endfunction

  task automatic modelReset();
    logic [NF*FB-1:0] iv;
    iv = INIT;
    for (int f = 0; f < NF; f++) begin
      mShadow[f] = iv[f*FB +: FB] & fmask(f);
      mActive[f] = mShadow[f];
    end
    mDirty = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doWrite(input logic [NF-1:0] strobe, input logic [FB-1:0] data);
    bus.FrameStrobe = strobe;
    bus.FrameData   = data;
    tick();
    bus.FrameStrobe = '0;
    for (int f = 0; f < NF; f++) begin
      if (strobe[f]) mShadow[f] = data & fmask(f);
    end
    mDirty = mDirty | strobe;
  endtask

  task automatic doCommit();
    bus.commit_req = 1'b1;
    tick();
    tick();
    bus.commit_req = 1'b0;
    tick();
    tick();
    for (int f = 0; f < NF; f++) mActive[f] = mShadow[f];
    mDirty = '0;
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    bus.FrameData   = '0;
    bus.FrameStrobe = '0;
    bus.commit_req  = 1'b0;
    bus.abort       = 1'b0;
    bus.ReadbackSel = '0;
    modelReset();
    tick();
    tick();
    checks++; if (bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL reset_cfg got=%h exp=%h", bus.ConfigBits, expCfg()); end
    checks++; if (bus.ConfigBits_N !== ~expCfg()) begin failures++; $display("[TB] FAIL reset_cfgN got=%h exp=%h", bus.ConfigBits_N, ~expCfg()); end
    checks++; if (bus.frames_dirty !== 20'h0) begin failures++; $display("[TB] FAIL reset_dirty got=%h exp=0", bus.frames_dirty); end
    checks++; if (bus.commit_ack !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack_busy got=%b%b exp=00", bus.commit_ack, bus.busy); end
    checks++; if (bus.ReadbackData !== 32'h0) begin failures++; $display("[TB] FAIL reset_rb got=%h exp=0", bus.ReadbackData); end
    resetn = 1'b1;
    tick();
    checks++; if (bus.ReadbackData !== 32'h00000020) begin failures++; $display("[TB] FAIL reset_rb0 got=%h exp=00000020", bus.ReadbackData); end
  endtask

  task automatic test_write_commit();
    doWrite(20'h00008, 32'hDEADBEEF);
    checks++; if (bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL wr_cfg_unchanged got=%h exp=%h", bus.ConfigBits, expCfg()); end
    checks++; if (bus.frames_dirty !== 20'h00008) begin failures++; $display("[TB] FAIL wr_dirty got=%h exp=00008", bus.frames_dirty); end
    bus.ReadbackSel = 5'd3;
    tick();
    checks++; if (bus.ReadbackData !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_rb3 got=%h exp=deadbeef", bus.ReadbackData); end
    bus.commit_req = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b1 || bus.commit_ack !== 1'b0 || bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL copy_cycle busy=%b ack=%b (exp 1,0, cfg unchanged)", bus.busy, bus.commit_ack); end
    tick();
    for (int f = 0; f < NF; f++) mActive[f] = mShadow[f];
    mDirty = '0;
    checks++; if (bus.commit_ack !== 1'b1) begin failures++; $display("[TB] FAIL ack_rise got=%b exp=1", bus.commit_ack); end
    checks++; if (bus.ConfigBits[127:96] !== 32'hDEADBEEF || bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL commit_cfg got=%h exp=deadbeef", bus.ConfigBits[127:96]); end
    checks++; if (bus.frames_dirty !== 20'h0) begin failures++; $display("[TB] FAIL commit_dirty got=%h exp=0", bus.frames_dirty); end
    repeat (3) tick();
    checks++; if (bus.commit_ack !== 1'b1) begin failures++; $display("[TB] FAIL ack_hold got=%b exp=1", bus.commit_ack); end
    bus.commit_req = 1'b0;
    tick();
    checks++; if (bus.commit_ack !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL ack_fall ack=%b busy=%b exp=0,0", bus.commit_ack, bus.busy); end
  endtask

  task automatic test_frame18();
    doWrite(20'h40000, 32'hFFFFFFFF);
    bus.ReadbackSel = 5'd18;
    tick();
    checks++; if (bus.ReadbackData !== 32'h00FFFFFF) begin failures++; $display("[TB] FAIL rb18 got=%h exp=00ffffff", bus.ReadbackData); end
    bus.ReadbackSel = 5'd19;
    tick();
    checks++; if (bus.ReadbackData !== 32'h0) begin failures++; $display("[TB] FAIL rb19 got=%h exp=0", bus.ReadbackData); end
    bus.ReadbackSel = 5'd27;
    tick();
    checks++; if (bus.ReadbackData !== 32'h0) begin failures++; $display("[TB] FAIL rb_oor got=%h exp=0", bus.ReadbackData); end
    doCommit();
    checks++; if (bus.ConfigBits[599:576] !== 24'hFFFFFF || bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL cfg18 got=%h exp=ffffff", bus.ConfigBits[599:576]); end
  endtask

  task automatic test_back_to_back();
    bus.commit_req = 1'b1;
    tick();
    bus.FrameStrobe = 20'h00002;
    bus.FrameData   = 32'h12345678;
    tick();
    bus.FrameStrobe = '0;
    for (int f = 0; f < NF; f++) mActive[f] = mShadow[f];
    mShadow[1] = 32'h12345678;
    mDirty = 20'h00002;
    checks++; if (bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL b2b_old_cfg got=%h exp=%h", bus.ConfigBits[63:32], mActive[1]); end
    checks++; if (bus.frames_dirty !== 20'h00002) begin failures++; $display("[TB] FAIL b2b_dirty got=%h exp=00002", bus.frames_dirty); end
    bus.commit_req = 1'b0;
    tick();
    tick();
    checks++; if (bus.commit_ack !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ack got=%b exp=0", bus.commit_ack); end
    doCommit();
    checks++; if (bus.ConfigBits[63:32] !== 32'h12345678 || bus.frames_dirty !== 20'h0) begin failures++; $display("[TB] FAIL b2b_second got=%h exp=12345678", bus.ConfigBits[63:32]); end
  endtask

  task automatic test_abort();
    doWrite(20'h00005, 32'hA5A5A5A5);
    checks++; if (bus.frames_dirty !== mDirty) begin failures++; $display("[TB] FAIL abort_predirty got=%h exp=%h", bus.frames_dirty, mDirty); end
    bus.abort      = 1'b1;
    bus.commit_req = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.commit_ack !== 1'b0) begin failures++; $display("[TB] FAIL abort_revert busy=%b ack=%b exp=1,0", bus.busy, bus.commit_ack); end
    tick();
    for (int f = 0; f < NF; f++) mShadow[f] = mActive[f];
    mDirty = '0;
    checks++; if (bus.frames_dirty !== 20'h0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_done dirty=%h busy=%b exp=0,0", bus.frames_dirty, bus.busy); end
    bus.ReadbackSel = 5'd0;
    tick();
    checks++; if (bus.ReadbackData !== mShadow[0]) begin failures++; $display("[TB] FAIL abort_rb0 got=%h exp=%h", bus.ReadbackData, mShadow[0]); end
    tick();
    checks++; if (bus.commit_ack !== 1'b1 || bus.ConfigBits !== expCfg()) begin failures++; $display("[TB] FAIL abort_commit ack=%b exp=1 cfg must be unchanged", bus.commit_ack); end
    bus.commit_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [NF-1:0]  s;
    logic [FB-1:0]  d;
    logic [RSW-1:0] sel;
    logic [FB-1:0]  e;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          s = NF'($urandom);
          d = $urandom;
          doWrite(s, d);
        end
        2: begin
          sel = RSW'($urandom_range(0, 31));
          bus.ReadbackSel = sel;
          tick();
          e = (int'(sel) < NF) ? mShadow[sel] : 32'h0;
          checks++; if (bus.ReadbackData !== e) begin failures++; $display("[TB] FAIL rand_rb it=%0d sel=%0d got=%h exp=%h", it, sel, bus.ReadbackData, e); end
        end
        3: doCommit();
        default: begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          tick();
          for (int f = 0; f < NF; f++) mShadow[f] = mActive[f];
          mDirty = '0;
        end
      endcase
      checks++; if (bus.ConfigBits !== expCfg() || bus.ConfigBits_N !== ~expCfg()) begin failures++; $display("[TB] FAIL rand_cfg it=%0d got=%h exp=%h", it, bus.ConfigBits, expCfg()); end
      checks++; if (bus.frames_dirty !== mDirty) begin failures++; $display("[TB] FAIL rand_dirty it=%0d got=%h exp=%h", it, bus.frames_dirty, mDirty); end
    end
  endtask

  task automatic test_reset_mid_commit();
    doWrite(20'h00010, 32'hCAFEF00D);
    doCommit();
    bus.commit_req = 1'b1;
    tick();
    tick();
    checks++; if (bus.commit_ack !== 1'b1) begin failures++; $display("[TB] FAIL midrst_pre_ack got=%b exp=1", bus.commit_ack); end
    resetn = 1'b0;
    #1;
    modelReset();
    checks++; if (bus.commit_ack !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ack_busy ack=%b busy=%b exp=0,0", bus.commit_ack, bus.busy); end
    checks++; if (bus.ConfigBits !== expCfg() || bus.frames_dirty !== 20'h0) begin failures++; $display("[TB] FAIL midrst_cfg got=%h exp=%h", bus.ConfigBits, expCfg()); end
    bus.commit_req = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_commit();
    test_frame18();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid_commit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_config_mem_shadowed.md
Name: tile_config_mem_shadowed

Overview:
Clocked, parametrised successor to the per-tile frame-latch configuration memory. Frames are written into a shadow bank via FrameData/FrameStrobe. A 4-phase commit handshake atomically copies the shadow bank to the active bank that drives ConfigBits/ConfigBits_N, so partial reconfiguration never exposes a half-written tile. Adds dirty-frame tracking, abort (revert shadow to active), per-frame readback, and a reset-loaded initial bitstream that replaces the compile-time emulation path.

Parameters:
MaxFramesPerCol, 20, number of frames (FrameStrobe width)
FrameBitsPerRow, 32, bits per frame (FrameData width)
NoConfigBits, 0, config bits used; must be <= MaxFramesPerCol*FrameBitsPerRow; 0 is legal (no storage)
Init_Bitstream, {MaxFramesPerCol*FrameBitsPerRow{1'b0}}, value loaded into both banks on reset
RbSelWidth, 5, width of ReadbackSel; must be >= clog2(MaxFramesPerCol)

Ports:
CLK  in  1  configuration clock
resetn  in  1  asynchronous, active-low reset
FrameData  in  FrameBitsPerRow  frame write data
FrameStrobe  in  MaxFramesPerCol  per-frame write enable; multiple bits set writes the same data to every strobed frame
commit_req  in  1  4-phase commit request (level)
commit_ack  out  1  4-phase commit acknowledge
abort  in  1  single-cycle pulse; discard shadow contents
ReadbackSel  in  RbSelWidth  frame index for readback
ReadbackData  out  FrameBitsPerRow  registered shadow-frame readback
frames_dirty  out  MaxFramesPerCol  frames written since last commit/abort
busy  out  1  high whenever state != IDLE
ConfigBits  out  NoConfigBits  active configuration
ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits, always

Behaviour:
- Mapping: config bit i <-> frame i/FrameBitsPerRow, bit i%FrameBitsPerRow. Frame bits beyond NoConfigBits are not stored: writes to them are ignored and they read back 0.
- Reset (async assert, sync release): shadow = active = Init_Bitstream[NoConfigBits-1:0]; frames_dirty=0; commit_ack=0; ReadbackData=0; state IDLE; busy=0.
- Frame write: at a CLK edge with FrameStrobe[f]=1, shadow frame f <= FrameData and frames_dirty[f] <= 1. Writes are accepted in every state; only abort overrides them.
- Readback: ReadbackData <= shadow frame ReadbackSel, 1-cycle latency. It shows pre-write data if the selected frame is written in the same edge. Out-of-range select returns 0.
- FSM states: IDLE, COPY, ACK, WAIT_LOW, REVERT.
  - IDLE: abort=1 -> REVERT. Else commit_req=1 -> COPY.
  - COPY: at the exiting edge, active <= shadow (value before any same-edge write). frames_dirty <= only frames strobed on that same edge (those stay dirty). Next state ACK.
  - ACK: commit_ack=1. Next state WAIT_LOW.
  - WAIT_LOW: commit_ack stays 1 until commit_req=0 is sampled. Then commit_ack <= 0 and next state IDLE. There is no re-trigger without commit_req falling.
  - REVERT: at the exiting edge, shadow <= active and frames_dirty <= 0. Same-edge FrameStrobe is discarded. Next state IDLE.
- Abort outside IDLE is ignored, no latching.
- Simultaneous abort and commit_req in IDLE: abort wins. The commit then starts from IDLE on a later cycle if commit_req is still high.
- Latency: commit_req rises in cycle 0 (IDLE) -> COPY in cycle 1 -> ConfigBits updated and commit_ack=1 from cycle 2.
- ConfigBits changes only at the COPY exit edge and at reset, never on a frame write.
- Reset mid-commit: everything returns to Init_Bitstream and IDLE; commit_ack deasserts asynchronously.
- busy is combinational from state.

Test Plan:
- Reset with Init_Bitstream bit 5 = 1, NoConfigBits=600 -> ConfigBits=0x...20, ConfigBits_N=~that, frames_dirty=0, ReadbackSel=0 gives 0x00000020 one cycle later.
- Write frame 3 = 0xDEADBEEF, no commit -> ConfigBits unchanged, frames_dirty=0x00008, readback of frame 3 = 0xDEADBEEF. Then raise commit_req -> ConfigBits[127:96]=0xDEADBEEF two cycles later, commit_ack high until commit_req falls, frames_dirty=0.
- Frame 18 (bits 576..607, NoConfigBits=600): write 0xFFFFFFFF -> readback 0x00FFFFFF, ConfigBits[599:576] all 1 after commit.
- Write frame 1 = 0x12345678 in the same cycle COPY exits -> active gets the old frame 1, frames_dirty=0x00002, a second commit applies 0x12345678.
- Write frames 0 and 2 (FrameStrobe=0x5, data 0xA5A5A5A5), then abort together with commit_req -> REVERT taken, shadow restored, frames_dirty=0, readback of frame 0 = the old value. The commit then completes with ConfigBits unchanged.
- Assert resetn=0 while in ACK -> commit_ack=0 immediately, ConfigBits=Init_Bitstream, busy=0.
